data_mem_responder: RTL
=======================

# data_mem_responder

Memory-side responder for the core's data cache: a byte-addressed, big-endian data memory with a fixed, parameterised access latency. It sits outside `mips_core` and drives `mem_data_out` in reply to the cache's `mem_addr`, `mem_data_in` and `mem_write_en`. It models the slow main memory the cache's multi-cycle stall logic is built around, and is synthesisable for FPGA bring-up.

## Interface
- `ADDR_BITS`, default 16: byte-address bits decoded; storage is 2**ADDR_BITS bytes.
- `LATENCY`, default 4, legal 1..15: cycles `mem_addr` must be stable before a read or write completes.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_b`  in  1  reset: asynchronous, active-low.
- `mem_addr`  in  32  byte address; bits [1:0] ignored (word-aligned); bits above ADDR_BITS-1 ignored (wrap).
- `mem_data_in`  in  8 x [0:3]  write data; lane 0 is the most significant byte and goes to address +0.
- `mem_write_en`  in  1  write request for the current address.
- `mem_data_out`  out  8 x [0:3]  registered read data; lane 0 is the byte at address +0.
- `mem_ready`  out  1  high while the access at the current address has completed.
- `busy_cycles`  out  32  free-running count of cycles spent in WAIT, for performance counters.

## Operation
- States: WAIT and DONE. Internal registers:
  - `cnt`: 4 bits.
  - `addr_q`: word address.
  - `we_q`: last sampled `mem_write_en`.
- Restart condition: any edge where `mem_addr[ADDR_BITS-1:2] != addr_q` or `mem_write_en != we_q`.
  - On restart: `addr_q` and `we_q` load, `cnt` is set to 1, state goes to WAIT.
  - Restart has priority in every state.
- WAIT: `cnt` increments each cycle with no restart. When `cnt == LATENCY` the access completes on that edge:
  - Read (`we_q` = 0): `mem_data_out` loads the 4 bytes at `{addr_q,2'b00}` .. +3.
  - Write (`we_q` = 1): the 4 bytes are written from `mem_data_in` as sampled on that edge. `mem_data_out` loads the same data (write-through echo).
  - State goes to DONE.
- DONE: `mem_ready` = 1. No further writes occur, even if `mem_write_en` stays high; exactly one commit happens per restart. `mem_data_out` holds its value. `busy_cycles` does not increment.
- Storage is not cleared by reset. Contents are X until written or preloaded via `$readmemh` (simulation only; file name is a plusarg).
- `busy_cycles` increments in every WAIT cycle and wraps at 2**32.

## Timing
- Reset values: state WAIT, `cnt` 0, `addr_q` 0, `we_q` 0, `mem_data_out` all lanes 8'h00, `mem_ready` 0, `busy_cycles` 0.
  - After reset release, the first edge is treated as a restart.
- Completion latency: address/write-enable stable at edge N (restart), so completion happens at edge N+LATENCY-1 and `mem_ready` is high after it.
  - LATENCY=1 therefore completes on the restart edge itself: `cnt` is set to 1, which equals LATENCY.
- `mem_ready` is registered. It drops on the edge after a restart is seen, not combinationally.
- Address changing mid-WAIT: the in-flight access is abandoned. No partial write occurs and `mem_data_out` keeps its old value.
- Reset asserted mid-WAIT of a write: no write happens.
- Simultaneous restart and completion: restart wins and the access does not commit.

## Structure
- Package `mips_mem_pkg` holds:
  - `byte_t` (logic [7:0]) and `word_bytes_t` (byte_t [0:3]);
  - the state enum `mem_state_e` {WAIT, DONE};
  - the constant `MEM_LATENCY_DEFAULT` = 4.
- One sub-module, `mem_latency_tracker`, owns the restart detection, `cnt`, state, `mem_ready` and `busy_cycles`. It outputs a one-cycle `complete` strobe. The top level owns the byte array and the data path.

## Test plan
- Reset, then read address 0x0 with LATENCY=4 and contents 11 22 33 44: `mem_ready` rises after edge 4 and `mem_data_out` = {11,22,33,44}. Lanes are 0 before completion.
- Write 0xDEADBEEF to 0x100 with `mem_write_en` held 8 cycles: exactly one commit. A later read of 0x100 returns DE AD BE EF, and a read of 0x102 also returns the word (bits [1:0] ignored).
- Change address from 0x10 to 0x20 at cnt=2 during a write: 0x10 is unchanged, and 0x20 completes LATENCY edges after the change.
- Address 0x0001_0004 with ADDR_BITS=16 aliases to 0x0004.
- Assert `rst_b` low mid-write: outputs go to zero immediately and memory is unmodified. `busy_cycles` is 0 after release.
- LATENCY=1: back-to-back address changes every cycle give `mem_ready` = 1 each cycle with the correct data, and `busy_cycles` stays 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory responder slice.
`timescale 1ns/1ps
package mips_mem_pkg;

  typedef logic [7:0] byte_t;
  // Lane 0 is the most significant byte and maps to byte address +0 (big-endian).
  typedef byte_t [0:3] word_bytes_t;

  typedef enum logic [0:0] {
    WAIT = 1'b0,
    DONE = 1'b1
  } mem_state_e;

  localparam int unsigned MEM_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/mem_latency_tracker.sv
// Access-latency tracker: detects restarts, counts stable cycles, raises a
// one-cycle completion strobe and keeps the ready flag and busy counter.
`timescale 1ns/1ps
module mem_latency_tracker
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned LATENCY   = MEM_LATENCY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [ADDR_BITS-3:0] addr_word_i,
  input  logic                 we_i,
  output logic                 complete_o,
  output logic                 mem_ready_o,
  output logic [31:0]          busy_cycles_o
);

  localparam logic [3:0] LAT_C = 4'(LATENCY);

  mem_state_e             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-3:0]   addr_q, addr_d;
  logic                   we_q, we_d;
  // Forces the first edge after reset release to behave as a restart.
  logic                   first_q;
  logic                   ready_q, ready_d;
  logic [31:0]            busy_q, busy_d;
  logic                   restart_s;
  logic                   complete_s;

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= WAIT;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      first_q <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      first_q <= 1'b0;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: restart beats everything, including a same-edge completion.
  always_comb begin
    restart_s  = first_q || (addr_word_i != addr_q) || (we_i != we_q);
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    complete_s = 1'b0;
    if (restart_s) begin
      addr_d = addr_word_i;
      we_d   = we_i;
      cnt_d  = 4'd1;
      // With LATENCY of 1 the new access completes on its own restart edge.
      complete_s = (cnt_d == LAT_C);
      state_d    = complete_s ? DONE : WAIT;
    end else begin
      case (state_q)
        WAIT: begin
          cnt_d      = cnt_q + 4'd1;
          complete_s = (cnt_d == LAT_C);
          state_d    = complete_s ? DONE : WAIT;
        end
        DONE: begin
          cnt_d   = cnt_q;
          state_d = DONE;
        end
        default: begin
          cnt_d   = 4'd0;
          state_d = WAIT;
        end
      endcase
    end
  end

  // Output logic: strobe, next ready flag and busy count of cycles spent waiting.
  always_comb begin
    complete_o = complete_s;
    ready_d    = (state_d == DONE);
    if (state_d == WAIT) begin
      busy_d = busy_q + 32'd1;
    end else begin
      busy_d = busy_q;
    end
  end

  assign mem_ready_o   = ready_q;
  assign busy_cycles_o = busy_q;

endmodule

// File: rtl/data_mem_responder.sv
// Big-endian, byte-addressed data memory with a fixed access latency that
// answers the data cache; owns the byte array and the read/write data path.
`timescale 1ns/1ps
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned LATENCY   = MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] mem_addr,
  input  word_bytes_t mem_data_in,
  input  logic        mem_write_en,
  output word_bytes_t mem_data_out,
  output logic        mem_ready,
  output logic [31:0] busy_cycles
);

  byte_t                mem_q [2**ADDR_BITS];
  word_bytes_t          data_q;
  word_bytes_t          rd_word_s;
  logic [ADDR_BITS-3:0] word_s;
  logic                 complete_s;
  logic                 unused_addr_bits_s;

  // Byte-offset bits and bits above the decoded range are ignored (aliasing).
  assign word_s             = mem_addr[ADDR_BITS-1:2];
  assign unused_addr_bits_s = ^{mem_addr[1:0], mem_addr[31:ADDR_BITS]};

  mem_latency_tracker #(
    .ADDR_BITS (ADDR_BITS),
    .LATENCY   (LATENCY)
  ) u_tracker (
    .clk           (clk),
    .rst_b         (rst_b),
    .addr_word_i   (word_s),
    .we_i          (mem_write_en),
    .complete_o    (complete_s),
    .mem_ready_o   (mem_ready),
    .busy_cycles_o (busy_cycles)
  );

  // Gather the four bytes of the addressed word, lane 0 at byte offset 0.
  always_comb begin
    rd_word_s = {4{8'h00}};
    for (int i = 0; i < 4; i++) begin
      rd_word_s[i] = mem_q[{word_s, 2'(i)}];
    end
  end

  // Storage write: one commit per access, never while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_b && complete_s && mem_write_en) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[{word_s, 2'(i)}] <= mem_data_in[i];
      end
    end
  end

  // Registered read data; writes echo the stored data back.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      data_q <= {4{8'h00}};
    end else if (complete_s) begin
      data_q <= mem_write_en ? mem_data_in : rd_word_s;
    end
  end

  assign mem_data_out = data_q;

endmodule
